// File: rtl/spike_aer_if.sv
// Spike-frame input and address-event output bundle of the AER encoder.
// master = frame source / event consumer side, slave = encoder side.
interface spike_aer_if #(
    parameter int FRAME_W = 8
);
    logic [127:0]       population;
    logic               frame_valid;
    logic               aer_ready;
    logic               aer_valid;
    logic [6:0]         aer_addr;
    logic [FRAME_W-1:0] aer_frame;
    logic [7:0]         frame_spike_count;
    logic               frame_done;
    logic               busy;
    logic               events_dropped;
    logic               frame_overrun;

    modport master (
        output population, frame_valid, aer_ready,
        input  aer_valid, aer_addr, aer_frame, frame_spike_count,
               frame_done, busy, events_dropped, frame_overrun
    );

    modport slave (
        input  population, frame_valid, aer_ready,
        output aer_valid, aer_addr, aer_frame, frame_spike_count,
               frame_done, busy, events_dropped, frame_overrun
    );
endinterface

// File: rtl/spike_aer_encoder.sv
// Scans a 128-bit spike frame one neuron per cycle and emits one
// (frame ID, neuron index) address-event per set bit through a small FIFO.
module spike_aer_encoder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    spike_aer_if.slave  aer
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = FRAME_W + 7;
    localparam logic [FRAME_W-1:0] FID_ONE = FRAME_W'(1);
    localparam logic [AW-1:0]      PTR_ONE = AW'(1);
    localparam logic [AW:0]        OCC_ONE = (AW+1)'(1);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t             r_state;
    logic [127:0]       r_scan;
    logic [6:0]         r_idx;
    logic [7:0]         r_cnt;
    logic [FRAME_W-1:0] r_fid;
    logic [7:0]         r_frame_cnt;
    logic               r_done;
    logic               r_dropped;
    logic               r_overrun;

    logic [EW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_occ;

    logic               w_valid;
    logic               w_full;
    logic               w_bit;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [7:0]         w_cnt_next;
    logic [EW-1:0]      w_head;

    // Occupancy never exceeds FIFO_DEPTH, so its MSB alone marks "full".
    assign w_valid    = |r_occ;
    assign w_full     = r_occ[AW];
    assign w_bit      = (r_state == S_SCAN) && r_scan[0];
    assign w_pop      = w_valid && aer.aer_ready;
    assign w_push     = w_bit && (!w_full || w_pop);
    assign w_drop     = w_bit && w_full && !w_pop;
    assign w_cnt_next = r_cnt + {7'd0, w_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_fid       <= '0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
            r_dropped   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_drop)
                r_dropped <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (aer.frame_valid) begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (aer.frame_valid)
                        r_overrun <= 1'b1;
                    r_cnt <= w_cnt_next;
                    if (r_idx == 7'd127) begin
                        r_state     <= S_IDLE;
                        r_frame_cnt <= w_cnt_next;
                        r_done      <= 1'b1;
                        r_fid       <= r_fid + FID_ONE;
                    end else begin
                        r_idx <= r_idx + 7'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scan vector shifts right so the neuron under test is always bit 0.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && aer.frame_valid)
            r_scan <= aer.population;
        else if (r_state == S_SCAN)
            r_scan <= r_scan >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {r_fid, r_idx};
    end

    // Head is forced to zero when empty so the outputs match their reset value.
    assign w_head = w_valid ? r_mem[r_rptr] : '0;

    assign aer.aer_valid         = w_valid;
    assign aer.aer_addr          = w_head[6:0];
    assign aer.aer_frame         = w_head[EW-1:7];
    assign aer.frame_spike_count = r_frame_cnt;
    assign aer.frame_done        = r_done;
    assign aer.busy              = (r_state == S_SCAN);
    assign aer.events_dropped    = r_dropped;
    assign aer.frame_overrun     = r_overrun;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed scenarios plus random
// frames compared against an event list derived from the set bits of each frame.
module tb_spike_aer_encoder;
    localparam int DEPTH = 16;
    localparam int FW    = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spike_aer_if #(.FRAME_W(FW)) bus();

    spike_aer_encoder #(.FIFO_DEPTH(DEPTH), .FRAME_W(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .aer   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit   rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b0;
    always @(posedge clk) begin
        #2;
        bus.aer_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    typedef struct {
        int          f;
        int          a;
        int unsigned t;
    } ev_t;
    ev_t got[$];

    // Each accepted event is logged with the cycle stamp of its first visible cycle.
    always @(negedge clk) begin
        if (bus.aer_valid === 1'b1 && bus.aer_ready === 1'b1)
            got.push_back('{int'(bus.aer_frame), int'(bus.aer_addr), cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_aer_valid"}, 32'(bus.aer_valid), 0);
        chk({tag, "_aer_addr"},  32'(bus.aer_addr), 0);
        chk({tag, "_aer_frame"}, 32'(bus.aer_frame), 0);
        chk({tag, "_count"},     32'(bus.frame_spike_count), 0);
        chk({tag, "_done"},      32'(bus.frame_done), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
        chk({tag, "_dropped"},   32'(bus.events_dropped), 0);
        chk({tag, "_overrun"},   32'(bus.frame_overrun), 0);
    endtask

    task automatic send_frame(input logic [127:0] v, output int unsigned t);
        @(posedge clk);
        #1;
        bus.population  = v;
        bus.frame_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input string tag, output int unsigned t);
        bit found;
        found = 1'b0;
        t = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                found = 1'b1;
                t = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(found), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
    endtask

    // Expected events: one per set bit, ascending neuron index, tagged with fid.
    task automatic check_events(input string tag, input logic [127:0] v, input int fid,
                                input int first, input bit chk_time, input int unsigned t0);
        int n;
        n = 0;
        for (int i = 0; i < 128; i++) begin
            if (v[i]) begin
                if (first + n < got.size()) begin
                    chk($sformatf("%s_addr%0d", tag, n), got[first+n].a, i);
                    chk($sformatf("%s_frame%0d", tag, n), got[first+n].f, fid & 8'hFF);
                    if (chk_time)
                        chk($sformatf("%s_time%0d", tag, n), got[first+n].t - t0, 1 + i);
                end
                n++;
            end
        end
    endtask

    function automatic logic [127:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] v;
    logic [127:0] v1;
    int unsigned  t0;
    int unsigned  td;
    int           exp_fid;
    int           kbits;

    initial begin
        bus.population  = '0;
        bus.frame_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b0;
        exp_fid = 0;

        // Empty frame: no events, done 129 cycles after the strobe edge
        rdy_fixed = 1'b1;
        got.delete();
        send_frame('0, t0);
        wait_done("empty", td);
        chk("empty_done_time", td - t0, 128);
        chk("empty_count", 32'(bus.frame_spike_count), 0);
        chk("empty_busy", 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        chk("empty_no_events", got.size(), 0);
        exp_fid++;

        v = '0;
        v[3] = 1'b1;
        got.delete();
        send_frame(v, t0);
        wait_done("fid1", td);
        repeat (3) @(negedge clk);
        chk("fid1_n", got.size(), 1);
        check_events("fid1", v, exp_fid, 0, 1'b1, t0);

        do_reset();
        exp_fid = 0;

        // Bits 0, 5, 127 with the consumer always ready
        v = '0;
        v[0] = 1'b1;
        v[5] = 1'b1;
        v[127] = 1'b1;
        send_frame(v, t0);
        wait_done("sparse", td);
        chk("sparse_count", 32'(bus.frame_spike_count), 3);
        @(negedge clk);
        chk("sparse_done_pulse", 32'(bus.frame_done), 0);
        repeat (2) @(negedge clk);
        chk("sparse_n", got.size(), 3);
        check_events("sparse", v, exp_fid, 0, 1'b1, t0);
        chk("sparse_dropped", 32'(bus.events_dropped), 0);
        chk("sparse_overrun", 32'(bus.frame_overrun), 0);
        exp_fid++;

        // All ones with the consumer stalled: only the first DEPTH events survive
        rdy_fixed = 1'b0;
        got.delete();
        v = '1;
        send_frame(v, t0);
        wait_done("full", td);
        chk("full_count", 32'(bus.frame_spike_count), 128);
        chk("full_dropped", 32'(bus.events_dropped), 1);
        chk("full_none_popped", got.size(), 0);
        chk("full_head_valid", 32'(bus.aer_valid), 1);
        chk("full_head_addr", 32'(bus.aer_addr), 0);
        rdy_fixed = 1'b1;
        repeat (30) @(negedge clk);
        rdy_fixed = 1'b0;
        chk("full_drained_n", got.size(), DEPTH);
        check_events("full", {112'd0, 16'hFFFF}, exp_fid, 0, 1'b0, 0);
        chk("full_empty_after", 32'(bus.aer_valid), 0);
        exp_fid++;

        // Second strobe mid-scan is ignored but flagged
        do_reset();
        exp_fid = 0;
        rdy_fixed = 1'b1;
        v1 = rand_vec();
        send_frame(v1, t0);
        repeat (49) @(posedge clk);
        #1;
        bus.population  = '1;
        bus.frame_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        @(negedge clk);
        chk("ovr_flag", 32'(bus.frame_overrun), 1);
        chk("ovr_busy", 32'(bus.busy), 1);
        wait_done("ovr", td);
        chk("ovr_done_time", td - t0, 128);
        chk("ovr_count", 32'(bus.frame_spike_count), $countones(v1));
        repeat (150) @(negedge clk);
        chk("ovr_n", got.size(), $countones(v1));
        check_events("ovr", v1, exp_fid, 0, 1'b1, t0);
        chk("ovr_sticky", 32'(bus.frame_overrun), 1);
        chk("ovr_dropped", 32'(bus.events_dropped), 0);

        // Full FIFO while scanning all ones: every push pairs with a pop
        do_reset();
        exp_fid = 0;
        rdy_fixed = 1'b0;
        v = {112'd0, 16'hFFFF};
        send_frame(v, t0);
        wait_done("prefill", td);
        chk("prefill_none_popped", got.size(), 0);
        chk("prefill_dropped", 32'(bus.events_dropped), 0);
        @(posedge clk);
        #1;
        bus.population  = '1;
        bus.frame_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        rdy_fixed = 1'b1;
        wait_done("simul", td);
        repeat (25) @(negedge clk);
        chk("simul_dropped", 32'(bus.events_dropped), 0);
        chk("simul_count", 32'(bus.frame_spike_count), 128);
        chk("simul_n", got.size(), DEPTH + 128);
        check_events("simul_old", v, 0, 0, 1'b0, 0);
        check_events("simul_new", '1, 1, DEPTH, 1'b0, 0);

        // Asynchronous reset in the middle of a dense scan
        do_reset();
        rdy_fixed = 1'b0;
        send_frame('1, t0);
        repeat (59) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_fid = 0;
        rdy_fixed = 1'b1;
        got.delete();
        v = rand_vec() & rand_vec();
        send_frame(v, t0);
        wait_done("postrst", td);
        repeat (3) @(negedge clk);
        chk("postrst_n", got.size(), $countones(v));
        check_events("postrst", v, exp_fid, 0, 1'b1, t0);
        exp_fid++;

        // Random frames, consumer always ready
        for (int r = 0; r < 5; r++) begin
            got.delete();
            v = rand_vec();
            send_frame(v, t0);
            wait_done($sformatf("rnd%0d", r), td);
            chk($sformatf("rnd%0d_count", r), 32'(bus.frame_spike_count), $countones(v));
            repeat (3) @(negedge clk);
            chk($sformatf("rnd%0d_n", r), got.size(), $countones(v));
            check_events($sformatf("rnd%0d", r), v, exp_fid, 0, 1'b1, t0);
            exp_fid++;
        end

        // Sparse random frames with a randomly stalling consumer
        rdy_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            got.delete();
            v = '0;
            kbits = $urandom_range(1, DEPTH);
            for (int k = 0; k < kbits; k++)
                v[$urandom_range(0, 127)] = 1'b1;
            send_frame(v, t0);
            wait_done($sformatf("stall%0d", r), td);
            chk($sformatf("stall%0d_count", r), 32'(bus.frame_spike_count), $countones(v));
            repeat (80) @(negedge clk);
            chk($sformatf("stall%0d_n", r), got.size(), $countones(v));
            check_events($sformatf("stall%0d", r), v, exp_fid, 0, 1'b0, 0);
            exp_fid++;
        end
        rdy_rand = 1'b0;
        chk("final_dropped", 32'(bus.events_dropped), 0);
        chk("final_overrun", 32'(bus.frame_overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream stage of the time-multiplexed Izhikevich neuron array. It captures each 128-bit population spike frame and scans it one neuron per cycle, emitting one address-event (frame ID, neuron index) per set bit through a small FIFO with a valid/ready handshake. It also reports per-frame spike counts and sticky loss flags, which feed the host readout and downstream synapse logic.

## Interface
Parameters:
- FIFO_DEPTH, 16: event FIFO entries; power of two, 2..64.
- FRAME_W, 8: frame-ID width; wraps modulo 2^FRAME_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- population  in  128  spike vector; bit i = neuron i fired this frame.
- frame_valid  in  1  one-cycle strobe: population is valid this cycle.
- aer_ready  in  1  consumer accepts the current event.
- aer_valid  out  1  FIFO head holds a valid event.
- aer_addr  out  7  neuron index of the head event.
- aer_frame  out  FRAME_W  frame ID of the head event.
- frame_spike_count  out  8  set bits in the last completed frame (0..128).
- frame_done  out  1  one-cycle pulse when a scan completes.
- busy  out  1  high while scanning.
- events_dropped  out  1  sticky: an event was lost because the FIFO was full.
- frame_overrun  out  1  sticky: frame_valid arrived while busy.

## Operation
- States:
  - IDLE: on frame_valid, latch population into scan_reg, set idx=0, clear the running count, go to SCAN.
  - SCAN: each cycle examine scan_reg[idx].
    - If set: increment the running count and push {frame_id, idx}.
    - idx==127: go to IDLE, load frame_spike_count, pulse frame_done, increment frame_id (wraps).
    - Otherwise idx++.
- frame_id is 0 after reset. The first frame's events carry frame 0.
- Push rule: a push is accepted when count<FIFO_DEPTH, or when a pop happens in the same cycle.
  - Otherwise the event is discarded, events_dropped is set, and the running count still increments (the count reflects true spikes).
- Pop rule: a pop occurs when aer_valid && aer_ready. Simultaneous push and pop leave the occupancy unchanged.
- aer_addr and aer_frame are held stable while aer_valid=1 and aer_ready=0. Their value when aer_valid=0 is don't-care.
- frame_valid while busy: the frame is ignored, frame_overrun is set, and the current scan continues undisturbed.
- The count is 8 bits wide; 128 fits, so it never saturates.
- Sticky flags clear only on reset.
- Reset mid-scan: the scan is aborted, the FIFO is emptied, and every output returns to its reset value. The next frame_valid starts a fresh frame 0.

## Timing
- Reset values: aer_valid=0, aer_addr=0, aer_frame=0, frame_spike_count=0, frame_done=0, busy=0, events_dropped=0, frame_overrun=0.
- frame_valid sampled at edge T:
  - busy=1 from T+1.
  - Bit i is examined in cycle T+1+i.
  - The event for bit i is visible on aer_valid at T+2+i when the FIFO was empty and aer_ready is held high.
- Scan of bit 127 is at T+128. At T+129: busy=0, frame_done=1, frame_spike_count updated.
- A new frame_valid is accepted from cycle T+129. The neuron array frame period of 256 cycles never overruns.
- Throughput: one event per cycle when aer_ready is held high. Fall-through latency is 1 cycle.

## Test plan
- Reset, then population=0, frame_valid: no aer_valid. frame_done at T+129, frame_spike_count=0, frame_id advances to 1.
- Bits {0,5,127} set, aer_ready=1: events (0,0),(0,5),(0,127) appear at T+2, T+7, T+129; count=3; no flags.
- All 128 bits set, aer_ready=0, FIFO_DEPTH=16: the first 16 events (addresses 0..15) are retained, events_dropped=1, count=128. Then raise aer_ready and drain exactly 16 events in order.
- Second frame_valid 50 cycles into a scan: frame_overrun=1. The first frame's events and count are unaffected, and no events are produced for the second vector.
- Full FIFO with aer_ready=1 while scanning all-ones: every push succeeds via the simultaneous-pop rule, events_dropped stays 0, and 128 events are received.
- Assert reset at T+60 of a dense frame: all outputs return to zero asynchronously. The next frame's events carry aer_frame=0.
